// File: rtl/lenet_pool_stream.sv
// lenet_pool_stream
// Streaming region-of-interest pooler. It consumes a raster-order pixel stream
// and writes an OUT_SIZE x OUT_SIZE grid of pooled values (sum, average or max
// over BLK_W x BLK_H blocks) into the LeNet input RAM. Only the centred
// ROI contributes.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   in_valid        pixel present on in_data
//   in_sof          with in_valid: pixel is (0,0); starts (or restarts) a frame
//   in_data         pixel value
//   mode            00 SUM, 01 AVG, 10 MAX, 11 AVG; sampled at sof
//   invert          use (2^PIX_W-1)-pixel; sampled at sof
//   enable          0: frame is consumed without writes; sampled at sof
//   out_we          write strobe, one cycle after a block's last pixel
//   out_addr        by*OUT_SIZE+bx
//   out_data        pooled value, zero-extended
//   frame_done      pulse on the cycle after the write of the last grid address
//   busy            high while ACTIVE
//
// State | meaning
// IDLE  | waiting for in_valid & in_sof, other pixels ignored
// ACTIVE| counting pixels of a frame until x=WIDTH-1, y=HEIGHT-1
module lenet_pool_stream #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int PIX_W    = 8,
    parameter int BLK_W    = 8,
    parameter int BLK_H    = 8,
    parameter int OUT_SIZE = 28,
    parameter int X0       = (WIDTH - OUT_SIZE * BLK_W) / 2,
    parameter int Y0       = (HEIGHT - OUT_SIZE * BLK_H) / 2,
    parameter int ACC_W    = PIX_W + $clog2(BLK_W * BLK_H),
    parameter int ADDR_W   = $clog2(OUT_SIZE * OUT_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [PIX_W-1:0]  in_data,
    input  logic [1:0]        mode,
    input  logic              invert,
    input  logic              enable,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ACC_W-1:0]  out_data,
    output logic              frame_done,
    output logic              busy
);

    localparam int X_W   = $clog2(WIDTH);
    localparam int Y_W   = $clog2(HEIGHT);
    localparam int LBW   = $clog2(BLK_W);
    localparam int LBH   = $clog2(BLK_H);
    localparam int LOG_N = $clog2(BLK_W * BLK_H);
    localparam int BX_W  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    localparam logic [X_W:0] X_LO = (X_W+1)'(X0);
    localparam logic [X_W:0] X_HI = (X_W+1)'(X0 + OUT_SIZE * BLK_W);
    localparam logic [Y_W:0] Y_LO = (Y_W+1)'(Y0);
    localparam logic [Y_W:0] Y_HI = (Y_W+1)'(Y0 + OUT_SIZE * BLK_H);

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_ACTIVE = 1'b1;

    logic              state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [1:0]        mode_q, mode_d;
    logic              inv_q, inv_d;
    logic              en_q, en_d;
    logic [ACC_W-1:0]  acc_q [OUT_SIZE];
    logic [ACC_W-1:0]  acc_d [OUT_SIZE];
    logic              out_we_q, out_we_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic              done_pend_q, done_pend_d;
    logic              frame_done_q, frame_done_d;

    // Per-pixel working signals
    logic              pix_fire;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic [1:0]        mode_e;
    logic              inv_e, en_e;
    logic              in_roi;
    logic [X_W-1:0]    rel_x;
    logic [Y_W-1:0]    rel_y;
    logic [BX_W-1:0]   bx, by;
    logic              blk_first, blk_last;
    logic [PIX_W-1:0]  pix;
    logic [ACC_W-1:0]  pix_ext, acc_cur, new_val;

    always_comb begin
        // A sof pixel is accepted in either state and becomes (0,0) with fresh config.
        pix_fire = in_valid && (in_sof || (state_q == S_ACTIVE));
        cur_x    = in_sof ? '0 : x_q;
        cur_y    = in_sof ? '0 : y_q;
        mode_e   = in_sof ? mode   : mode_q;
        inv_e    = in_sof ? invert : inv_q;
        en_e     = in_sof ? enable : en_q;

        in_roi = ({1'b0, cur_x} >= X_LO) && ({1'b0, cur_x} < X_HI) &&
                 ({1'b0, cur_y} >= Y_LO) && ({1'b0, cur_y} < Y_HI);
        rel_x  = cur_x - X_W'(X0);
        rel_y  = cur_y - Y_W'(Y0);
        bx     = BX_W'(rel_x >> LBW);
        by     = BX_W'(rel_y >> LBH);
        blk_first = (rel_x[LBW-1:0] == '0) && (rel_y[LBH-1:0] == '0);
        blk_last  = (rel_x[LBW-1:0] == '1) && (rel_y[LBH-1:0] == '1);

        pix     = inv_e ? ~in_data : in_data;
        pix_ext = ACC_W'(pix);
        acc_cur = acc_q[bx];

        if (blk_first)
            new_val = pix_ext;
        else if (mode_e == 2'b10)
            new_val = (pix_ext > acc_cur) ? pix_ext : acc_cur;
        else
            new_val = acc_cur + pix_ext;
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        mode_d       = mode_q;
        inv_d        = inv_q;
        en_d         = en_q;
        acc_d        = acc_q;
        out_we_d     = 1'b0;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        done_pend_d  = 1'b0;
        frame_done_d = done_pend_q;

        if (pix_fire) begin
            mode_d = mode_e;
            inv_d  = inv_e;
            en_d   = en_e;

            if (cur_x == X_W'(WIDTH - 1)) begin
                x_d = '0;
                if (cur_y == Y_W'(HEIGHT - 1)) begin
                    y_d     = '0;
                    state_d = S_IDLE;
                end else begin
                    y_d     = cur_y + 1'b1;
                    state_d = S_ACTIVE;
                end
            end else begin
                x_d     = cur_x + 1'b1;
                y_d     = cur_y;
                state_d = S_ACTIVE;
            end

            if (in_roi) begin
                acc_d[bx] = new_val;
                if (blk_last && en_e) begin
                    out_we_d   = 1'b1;
                    out_addr_d = ADDR_W'(by) * ADDR_W'(OUT_SIZE) + ADDR_W'(bx);
                    // mode 01 and the reserved 11 both average
                    out_data_d = mode_e[0] ? (new_val >> LOG_N) : new_val;
                    done_pend_d = (bx == BX_W'(OUT_SIZE - 1)) && (by == BX_W'(OUT_SIZE - 1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            mode_q       <= '0;
            inv_q        <= 1'b0;
            en_q         <= 1'b0;
            for (int i = 0; i < OUT_SIZE; i++) acc_q[i] <= '0;
            out_we_q     <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            mode_q       <= mode_d;
            inv_q        <= inv_d;
            en_q         <= en_d;
            acc_q        <= acc_d;
            out_we_q     <= out_we_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            done_pend_q  <= done_pend_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_we     = out_we_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_lenet_pool_stream.sv
// Testbench for lenet_pool_stream on a scaled-down frame: 16x12 pixels,
// 2x2 blocks, 4x4 grid, so the ROI is x 4..11, y 2..9 and addresses run 0..15.
module tb_lenet_pool_stream;

    localparam int WIDTH = 16, HEIGHT = 12, PIX_W = 8;
    localparam int BLK_W = 2, BLK_H = 2, OUT_SIZE = 4;
    localparam int ACC_W = 10, ADDR_W = 4, NBLK = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_sof = 1'b0;
    logic [PIX_W-1:0]  in_data = '0;
    logic [1:0]        mode = 2'b00;
    logic              invert = 1'b0;
    logic              enable = 1'b0;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [ACC_W-1:0]  out_data;
    logic              frame_done;
    logic              busy;

    lenet_pool_stream #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIX_W(PIX_W),
        .BLK_W(BLK_W), .BLK_H(BLK_H), .OUT_SIZE(OUT_SIZE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .mode(mode), .invert(invert), .enable(enable),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Output monitor, sampled on the falling edge
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [ACC_W-1:0]  wr_data_q [$];
    int done_cnt = 0, done_bad = 0, ncyc = 0, sof_n = -1, first_wr_n = -1;
    logic prev_last = 1'b0;

    always @(negedge clk) begin
        if (in_valid && in_sof && sof_n < 0) sof_n = ncyc;
        if (out_we) begin
            if (first_wr_n < 0) first_wr_n = ncyc;
            wr_addr_q.push_back(out_addr);
            wr_data_q.push_back(out_data);
        end
        if (frame_done) begin
            done_cnt++;
            if (!prev_last) done_bad++;
        end
        prev_last = out_we && (out_addr == ADDR_W'(NBLK - 1));
        ncyc++;
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0; done_bad = 0; sof_n = -1; first_wr_n = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_pix(input logic sof, input logic [PIX_W-1:0] d);
        in_valid = 1'b1; in_sof = sof; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    endtask

    // Drives a frame from row y_start (sof only when starting at row 0),
    // background bg with one hot pixel hv at (hx,hy), stopping before (sx,sy).
    // scramble changes mode/invert/enable right after the sof pixel.
    task automatic send_frame(input logic [1:0] m, input logic inv, input logic en,
                              input logic gaps, input logic scramble,
                              input logic [7:0] bg, input int hx, input int hy,
                              input logic [7:0] hv, input int sx, input int sy,
                              input int y_start);
        mode = m; invert = inv; enable = en;
        for (int y = y_start; y < HEIGHT; y++) begin
            for (int x = 0; x < WIDTH; x++) begin
                if (x == sx && y == sy) return;
                if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                drive_pix(x == 0 && y == 0, (x == hx && y == hy) ? hv : bg);
                if (scramble && x == 0 && y == 0) begin
                    mode = 2'b10; invert = ~inv; enable = ~en;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++; if (out_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", out_we); end
        checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", out_addr); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_avg_const();
        clear_mon();
        send_frame(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, -1, -1, 8'h00, -1, -1, 0);
        idle(4);
        checks++; if (wr_addr_q.size() != NBLK) begin errors++; $display("FAIL avg_count: got %0d want %0d", wr_addr_q.size(), NBLK); end
        for (int i = 0; i < NBLK; i++) begin
            checks++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== 10'h080) begin
                errors++; $display("FAIL avg_write[%0d]: got addr %0d data %h want addr %0d data 080", i,
                                   (i < wr_addr_q.size()) ? wr_addr_q[i] : 'x, (i < wr_data_q.size()) ? wr_data_q[i] : 'x, i);
            end
        end
        checks++; if (done_cnt != 1 || done_bad != 0) begin errors++; $display("FAIL avg_done: got %0d pulses (%0d misplaced) want 1", done_cnt, done_bad); end
        // block (0,0) ends at pixel (5,3) = index 53; write shows one cycle later
        checks++; if (first_wr_n - sof_n != 54) begin errors++; $display("FAIL avg_latency: got %0d want 54", first_wr_n - sof_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL avg_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_sum_const();
        clear_mon();
        // config changes after sof must not take effect
        send_frame(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, -1, -1, 8'h00, -1, -1, 0);
        idle(4);
        checks++; if (wr_addr_q.size() != NBLK) begin errors++; $display("FAIL sum_count: got %0d want %0d", wr_addr_q.size(), NBLK); end
        for (int i = 0; i < NBLK; i++) begin
            checks++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== 10'h3FC) begin
                errors++; $display("FAIL sum_write[%0d]: got data %h want 3fc", i, (i < wr_data_q.size()) ? wr_data_q[i] : 'x);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL sum_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_max_point(input logic gaps);
        clear_mon();
        // (7,5): rel (3,3) -> block (1,1) -> address 5
        send_frame(2'b10, 1'b0, 1'b1, gaps, 1'b0, 8'h10, 7, 5, 8'hC8, -1, -1, 0);
        idle(4);
        checks++; if (wr_addr_q.size() != NBLK) begin errors++; $display("FAIL max_count gaps=%0b: got %0d want %0d", gaps, wr_addr_q.size(), NBLK); end
        for (int i = 0; i < NBLK; i++) begin
            logic [ACC_W-1:0] exp_d;
            exp_d = (i == 5) ? 10'h0C8 : 10'h010;
            checks++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_d) begin
                errors++; $display("FAIL max_write[%0d] gaps=%0b: got data %h want %h", i, gaps,
                                   (i < wr_data_q.size()) ? wr_data_q[i] : 'x, exp_d);
            end
        end
        checks++; if (done_cnt != 1 || done_bad != 0) begin errors++; $display("FAIL max_done gaps=%0b: got %0d want 1", gaps, done_cnt); end
    endtask

    task automatic test_invert();
        clear_mon();
        send_frame(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, -1, -1, 8'h00, -1, -1, 0);
        idle(4);
        checks++; if (wr_addr_q.size() != NBLK) begin errors++; $display("FAIL inv_count: got %0d want %0d", wr_addr_q.size(), NBLK); end
        for (int i = 0; i < NBLK; i++) begin
            checks++;
            if (i >= wr_data_q.size() || wr_data_q[i] !== 10'h0FF) begin
                errors++; $display("FAIL inv_write[%0d]: got data %h want 0ff", i, (i < wr_data_q.size()) ? wr_data_q[i] : 'x);
            end
        end
    endtask

    task automatic test_disable();
        clear_mon();
        send_frame(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, -1, -1, 8'h00, -1, -1, 0);
        idle(4);
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL dis_writes: got %0d want 0", wr_addr_q.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL dis_done: got %0d want 0", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy: got %b want 0", busy); end
    endtask

    task automatic test_abort_sof();
        clear_mon();
        // stop mid-block at (5,7); the next frame's sof aborts it
        send_frame(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, -1, -1, 8'h00, 5, 7, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", busy); end
        clear_mon();
        send_frame(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, -1, -1, 8'h00, -1, -1, 0);
        idle(4);
        checks++; if (wr_addr_q.size() != NBLK) begin errors++; $display("FAIL abort_count: got %0d want %0d", wr_addr_q.size(), NBLK); end
        for (int i = 0; i < NBLK; i++) begin
            checks++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== 10'h080) begin
                errors++; $display("FAIL abort_write[%0d]: got data %h want 080", i, (i < wr_data_q.size()) ? wr_data_q[i] : 'x);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        send_frame(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, -1, -1, 8'h00, 0, 8, 0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        clear_mon();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        // remainder of the frame without sof must be ignored
        send_frame(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, -1, -1, 8'h00, -1, -1, 8);
        idle(4);
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL rstmid_writes: got %0d want 0", wr_addr_q.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_done: got %0d want 0", done_cnt); end
        clear_mon();
        send_frame(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, -1, -1, 8'h00, -1, -1, 0);
        idle(4);
        checks++; if (wr_addr_q.size() != NBLK) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", wr_addr_q.size(), NBLK); end
        for (int i = 0; i < NBLK; i++) begin
            checks++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== 10'h004) begin
                errors++; $display("FAIL rstmid_write[%0d]: got data %h want 004", i, (i < wr_data_q.size()) ? wr_data_q[i] : 'x);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_done_clean: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_avg_const();
        test_sum_const();
        test_max_point(1'b0);
        test_invert();
        test_disable();
        test_max_point(1'b1);
        test_abort_sof();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
